// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions for the host transmitter and the receiver.
//   ps2_state_t   transmitter FSM states
//   ERR_*         err_code values reported by ps2_host_tx
//   us_to_cycles  converts a time in microseconds to system clock cycles
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      BITS,
      ACK,
      WAITIDLE
   } ps2_state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_START = 2'b01;
   localparam logic [1:0] ERR_FRAME = 2'b10;
   localparam logic [1:0] ERR_NOACK = 2'b11;

   function automatic int us_to_cycles(input int us, input int hz);
      longint prod;
      prod = longint'(us) * longint'(hz);
      return int'(prod / 64'sd1000000);
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 line for use in the clk domain.
//   clk, reset_n  system clock, asynchronous active-low reset
//   pin           raw pin level (asynchronous)
//   level         filtered level; changes only after FILTER_LEN consecutive
//                 synchronized samples disagree with it
//   fall          one-cycle pulse when level goes 1 -> 0
// Idle PS/2 lines float high, so every stage resets to 1.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin,
   output logic level,
   output logic fall
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          s1, s2, level_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1      <= 1'b1;
         s2      <= 1'b1;
         level   <= 1'b1;
         level_d <= 1'b1;
         cnt     <= '0;
      end else begin
         s1      <= pin;
         s2      <= s1;
         level_d <= level;
         // Any agreeing sample restarts the run, so short glitches never pass.
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            level <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign fall = level_d & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter (open-drain clock/data).
//   clk, reset_n         system clock, asynchronous active-low reset
//   tx_data/tx_valid     byte to send, accepted when tx_valid && tx_ready
//   tx_ready             idle and able to accept a byte
//   busy                 transmission in progress (receiver discards frames)
//   done / err           one-cycle completion / failure pulse
//   err_code             01 start timeout, 10 frame timeout, 11 missing ack
//   ps2_clk_in/data_in   raw pin levels
//   ps2_clk_oe/data_oe   1 = pull the line low
// Build option PS2_TX_ACK_CHECK_EN: when defined, a high data line at the
// eleventh device clock fall reports ERR_NOACK; otherwise it is ignored.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_HZ           = 25000000,
   parameter int INHIBIT_US       = 120,
   parameter int START_TIMEOUT_US = 15000,
   parameter int FRAME_TIMEOUT_US = 2000,
   parameter int FILTER_LEN       = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int INH_CYC   = us_to_cycles(INHIBIT_US, CLK_HZ);
   localparam int START_CYC = us_to_cycles(START_TIMEOUT_US, CLK_HZ);
   localparam int FRAME_CYC = us_to_cycles(FRAME_TIMEOUT_US, CLK_HZ);
   localparam int MAX_CYC   = (START_CYC > FRAME_CYC) ?
                              ((START_CYC > INH_CYC) ? START_CYC : INH_CYC) :
                              ((FRAME_CYC > INH_CYC) ? FRAME_CYC : INH_CYC);
   localparam int TW        = $clog2(MAX_CYC + 1);

   logic clk_lvl, clk_fall, data_lvl, data_fall_unused;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk(clk), .reset_n(reset_n), .pin(ps2_clk_in),
      .level(clk_lvl), .fall(clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clk(clk), .reset_n(reset_n), .pin(ps2_data_in),
      .level(data_lvl), .fall(data_fall_unused)
   );

   ps2_state_t    state, state_n;
   logic [TW-1:0] tmr, tmr_n;
   logic [3:0]    bitcnt, bitcnt_n, nxt;
   logic [8:0]    frame, frame_n;   // {parity, data}, sent LSB first
   logic          clk_oe_n, data_oe_n, done_n, err_n;
   logic [1:0]    err_code_n;
`ifdef PS2_TX_ACK_CHECK_EN
   logic          ack_bad, ack_bad_n;
`endif

   // Ready only once the completion pulse has gone, so a new byte is never
   // accepted in the same cycle as done/err.
   assign tx_ready = (state == IDLE) && !done && !err;
   assign busy     = !tx_ready;
   assign nxt      = bitcnt + 4'd1;

   always_comb begin
      state_n    = state;
      tmr_n      = tmr + TW'(1);
      bitcnt_n   = bitcnt;
      frame_n    = frame;
      clk_oe_n   = ps2_clk_oe;
      data_oe_n  = ps2_data_oe;
      done_n     = 1'b0;
      err_n      = 1'b0;
      err_code_n = err_code;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_bad_n  = ack_bad;
`endif
      case (state)
         IDLE: begin
            tmr_n = '0;
            if (tx_valid && tx_ready) begin
               frame_n    = {~^tx_data, tx_data};
               err_code_n = ERR_NONE;
               clk_oe_n   = 1'b1;
               data_oe_n  = 1'b0;
               state_n    = INHIBIT;
            end
         end
         INHIBIT: begin
            if (tmr == TW'(INH_CYC - 1)) begin
               data_oe_n = 1'b1;   // start bit
               clk_oe_n  = 1'b0;   // request-to-send
               tmr_n     = '0;
               state_n   = REQ;
            end
         end
         REQ: begin
            if (clk_fall) begin
               bitcnt_n  = 4'd0;
               data_oe_n = ~frame[0];
               tmr_n     = '0;
               state_n   = BITS;
            end else if (tmr == TW'(START_CYC)) begin
               err_code_n = ERR_START;
               state_n    = IDLE;
            end
         end
         BITS: begin
            if (clk_fall) begin
               if (bitcnt == 4'd8) begin
                  data_oe_n = 1'b0;   // stop bit: release data
                  state_n   = ACK;
               end else begin
                  bitcnt_n  = nxt;
                  data_oe_n = ~frame[nxt];
               end
            end else if (tmr == TW'(FRAME_CYC)) begin
               err_code_n = ERR_FRAME;
               state_n    = IDLE;
            end
         end
         ACK: begin
            if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
               ack_bad_n = data_lvl;
`endif
               state_n = WAITIDLE;
            end else if (tmr == TW'(FRAME_CYC)) begin
               err_code_n = ERR_FRAME;
               state_n    = IDLE;
            end
         end
         WAITIDLE: begin
            if (clk_lvl && data_lvl) begin
               state_n = IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
               if (ack_bad) begin
                  err_n      = 1'b1;
                  err_code_n = ERR_NOACK;
               end else begin
                  done_n = 1'b1;
               end
`else
               done_n = 1'b1;
`endif
            end else if (tmr == TW'(FRAME_CYC)) begin
               err_code_n = ERR_FRAME;
               state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      // A timeout is the only way back to IDLE with err_code changed here.
      if (state != IDLE && state_n == IDLE && !done_n && !err_n) begin
         err_n     = 1'b1;
         clk_oe_n  = 1'b0;
         data_oe_n = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         tmr         <= '0;
         bitcnt      <= '0;
         frame       <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_code    <= ERR_NONE;
`ifdef PS2_TX_ACK_CHECK_EN
         ack_bad     <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         tmr         <= tmr_n;
         bitcnt      <= bitcnt_n;
         frame       <= frame_n;
         ps2_clk_oe  <= clk_oe_n;
         ps2_data_oe <= data_oe_n;
         done        <= done_n;
         err         <= err_n;
         err_code    <= err_code_n;
`ifdef PS2_TX_ACK_CHECK_EN
         ack_bad     <= ack_bad_n;
`endif
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a behavioural
// PS/2 device model on open-drain lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int HALF = 20;   // device clock half period in system cycles
   localparam int M_NORMAL = 0, M_NOCLK = 1, M_STOP5 = 2, M_NOACK = 3, M_GLITCH = 4;

   typedef struct {
      logic       is_err;
      logic [1:0] code;
   } exp_t;

   logic       clk, reset_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, busy, done, err;
   logic [1:0] err_code;
   logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
   logic       dev_clk, dev_data;

   assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .CLK_HZ(25000000), .INHIBIT_US(2), .START_TIMEOUT_US(40),
      .FRAME_TIMEOUT_US(30), .FILTER_LEN(8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .done(done), .err(err),
      .err_code(err_code), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
   );

   int   checks = 0, errors = 0;
   int   cyc = 0;
   exp_t sb[$];
   int   dev_mode = M_NORMAL;
   logic [7:0] cur_byte;
   int   dev_k = 0;
   bit   dev_abort = 0;
   int   out_cyc, clk_rel_cyc, clk_rise_cyc, data_rise_cyc, first_fall_cyc;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
      end
   endtask

   initial begin
      clk = 0;
      forever #20 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: pops the scoreboard on every done/err pulse.
   initial begin
      exp_t e;
      bit pend, pclk, pdat, inh;
      pend = 0; pclk = 0; pdat = 0; inh = 0;
      forever begin
         @(negedge clk);
         if (reset_n && (done || err)) begin
            out_cyc = cyc;
            chk("done_err_exclusive", int'(done & err), 0);
            chk("ready_during_pulse", int'(tx_ready), 0);
            if (sb.size() == 0) begin
               chk("unexpected_outcome", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("outcome_is_err", int'(err), int'(e.is_err));
               chk("err_code", int'(err_code), int'(e.code));
               pend = 1;
            end
         end else if (pend) begin
            chk("ready_after_pulse", int'(tx_ready), 1);
            chk("oe_released", int'(ps2_clk_oe | ps2_data_oe), 0);
            pend = 0;
         end
         if (ps2_clk_oe && !pclk) begin clk_rise_cyc = cyc; inh = 1; end
         if (!ps2_clk_oe && pclk) clk_rel_cyc = cyc;
         if (ps2_data_oe && !pdat && inh) begin data_rise_cyc = cyc; inh = 0; end
         pclk = ps2_clk_oe;
         pdat = ps2_data_oe;
      end
   end

   task automatic dwait(input int n);
      repeat (n) begin
         @(negedge clk);
         if (!reset_n) dev_abort = 1;
      end
   endtask

   // Device model: answers each request-to-send according to dev_mode and
   // checks the bits it sees against the byte's expected frame.
   initial begin
      logic smp[1:10];
      int nf;
      logic exp_bit;
      dev_clk = 1; dev_data = 1;
      forever begin
         @(negedge clk);
         if (reset_n && busy && !ps2_clk_oe && ps2_data_oe) begin
            dev_abort = 0;
            dwait(30);
            if (dev_mode == M_GLITCH) begin
               dwait(70);
               dev_clk = 0;
               dwait(2);
               dev_clk = 1;
            end else if (dev_mode != M_NOCLK) begin
               nf = (dev_mode == M_STOP5) ? 5 : 11;
               for (int k = 1; k <= nf; k++) begin
                  if (dev_abort) break;
                  dev_k = k;
                  dev_clk = 0;
                  if (k == 1) first_fall_cyc = cyc;
                  dwait(HALF);
                  dev_clk = 1;
                  dwait(HALF / 2);
                  if (k <= 10) smp[k] = ps2_data_in;
                  if (k == 10 && dev_mode != M_NOACK) dev_data = 0;
                  if (k == 11) dev_data = 1;
                  dwait(HALF / 2);
               end
               dev_clk = 1; dev_data = 1;
               if (!dev_abort) begin
                  for (int i = 1; i <= ((nf == 5) ? 5 : 10); i++) begin
                     if (i <= 8)       exp_bit = cur_byte[i-1];
                     else if (i == 9)  exp_bit = ($countones(cur_byte) % 2 == 0);
                     else              exp_bit = 1'b1;
                     chk($sformatf("wire_bit_fall%0d", i), int'(smp[i]), int'(exp_bit));
                  end
               end
            end
            dev_k = 0;
            for (int t = 0; t < 4000 && busy; t++) @(negedge clk);
         end
      end
   end

   function automatic exp_t expect_for(input int m);
      exp_t e;
      e.is_err = 1'b1;
      case (m)
         M_NOCLK, M_GLITCH: e.code = 2'b01;
         M_STOP5:           e.code = 2'b10;
`ifdef PS2_TX_ACK_CHECK_EN
         M_NOACK:           e.code = 2'b11;
`endif
         default: begin e.is_err = 1'b0; e.code = 2'b00; end
      endcase
      return e;
   endfunction

   task automatic send(input logic [7:0] d, input int m, input bit poke);
      int t;
      cur_byte = d;
      dev_mode = m;
      t = 0;
      while (!tx_ready && t < 2000) begin @(negedge clk); t++; end
      sb.push_back(expect_for(m));
      tx_data = d; tx_valid = 1;
      @(negedge clk);
      chk("ready_low_after_accept", int'(tx_ready), 0);
      chk("busy_after_accept", int'(busy), 1);
      chk("clk_oe_after_accept", int'(ps2_clk_oe), 1);
      tx_valid = 0;
      if (poke) begin
         repeat (100) @(negedge clk);
         tx_data = ~d; tx_valid = 1;
         repeat (5) @(negedge clk);
         tx_valid = 0;
      end
      t = 0;
      while (sb.size() != 0 && t < 3000) begin @(negedge clk); t++; end
      if (sb.size() != 0) begin
         chk("outcome_timeout", int'(sb.size()), 0);
         sb.delete();
      end
      repeat (60) @(negedge clk);
   endtask

   initial begin
      reset_n = 0; tx_valid = 0; tx_data = 0;
      repeat (3) @(negedge clk);
      chk("rst_oe", int'(ps2_clk_oe | ps2_data_oe), 0);
      reset_n = 1;
      @(negedge clk);
      chk("rst_tx_ready", int'(tx_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_err_code", int'(err_code), 0);
      chk("rst_clk_oe", int'(ps2_clk_oe), 0);
      chk("rst_data_oe", int'(ps2_data_oe), 0);

      send(8'hED, M_NORMAL, 1);
      send(8'hF4, M_NORMAL, 0);
      chk_rng("inhibit_cycles", data_rise_cyc - clk_rise_cyc, 50, 52);
      send(8'h3C, M_NOCLK, 0);
      chk_rng("start_timeout_cycles", out_cyc - clk_rel_cyc, 999, 1001);
      send(8'hA5, M_STOP5, 0);
      chk_rng("frame_timeout_cycles", out_cyc - first_fall_cyc, 755, 770);
      send(8'h12, M_NOACK, 0);
      send(8'h01, M_GLITCH, 0);
      for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 255)), M_NORMAL, 0);

      // Reset during bit 4: outputs must drop without waiting for a clock.
      cur_byte = 8'h00; dev_mode = M_NORMAL;
      tx_data = 8'h00; tx_valid = 1;
      @(negedge clk);
      tx_valid = 0;
      for (int t = 0; t < 2000 && dev_k != 5; t++) @(negedge clk);
      chk("reached_bit4", dev_k, 5);
      repeat (15) @(negedge clk);
      chk("data_oe_bit4", int'(ps2_data_oe), 1);
      #5 reset_n = 0;
      #1;
      chk("async_clk_oe", int'(ps2_clk_oe), 0);
      chk("async_data_oe", int'(ps2_data_oe), 0);
      repeat (3) @(negedge clk);
      reset_n = 1;
      @(negedge clk);
      chk("ready_after_reset", int'(tx_ready), 1);
      chk("busy_after_reset", int'(busy), 0);
      repeat (100) @(negedge clk);
      send(8'hF4, M_NORMAL, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #(40.0 * 90000);
      $display("FAIL global_timeout actual=%0d required=finish", cyc);
      $fatal(1);
   end

endmodule
